// File: rtl/scan_mux_reg.sv
// Registered N-channel, W-bit mux with manual select, masked auto-scan with
// per-channel dwell, and a valid/ready output stage.
module scan_mux_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          Select_Line,
    input  logic                      Mode,
    input  logic                      Enable,
    input  logic [CHANNELS-1:0]       Ch_Mask,
    input  logic                      Out_Ready,
    output logic [WIDTH-1:0]          Out,
    output logic                      Out_Valid,
    output logic [SEL_W-1:0]          Cur_Ch,
    output logic                      Sel_Err
);
    localparam int CNT_W = $clog2(DWELL + 1);

    logic [CHANNELS-1:0][WIDTH-1:0] ch;
    assign ch = I;

    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] dwell_cnt;
    logic             prev_mode;

    // First set mask bit at or after start, wrapping CHANNELS-1 -> 0.
    function automatic logic [SEL_W-1:0] first_set(input logic [CHANNELS-1:0] mask,
                                                   input int start);
        logic [CHANNELS-1:0] rot;
        int                  idx;
        logic                found;
        first_set = '0;
        found     = 1'b0;
        for (int off = 0; off < CHANNELS; off++) begin
            idx = start + off;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            rot = mask >> idx;
            if (!found && rot[0]) begin
                first_set = SEL_W'(idx);
                found     = 1'b1;
            end
        end
    endfunction

    logic             mode_sw, avail, load, sel_in_range;
    logic [SEL_W-1:0] base, eff, nxt, data_idx;
    logic [CNT_W-1:0] cnt_base, cnt_inc;
    logic [WIDTH-1:0] sel_data;
    int               nxt_start;

    always_comb begin
        mode_sw  = (Mode != prev_mode);
        base     = mode_sw ? '0 : ptr;
        cnt_base = mode_sw ? '0 : dwell_cnt;
        eff      = first_set(Ch_Mask, 32'(base));
        // Landing on a different channel than the pointer restarts its dwell.
        if (eff != base) cnt_base = '0;
        cnt_inc   = cnt_base + CNT_W'(1);
        nxt_start = 32'(eff) + 1;
        if (nxt_start >= CHANNELS) nxt_start = 0;
        nxt          = first_set(Ch_Mask, nxt_start);
        sel_in_range = (32'(Select_Line) < CHANNELS);
        data_idx     = Mode ? eff : Select_Line;
        sel_data     = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (32'(data_idx) == k) sel_data = ch[k];
        avail = Mode ? (|Ch_Mask) : 1'b1;
        load  = Enable & (~Out_Valid | Out_Ready) & avail;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out       <= '0;
            Out_Valid <= 1'b0;
            Cur_Ch    <= '0;
            Sel_Err   <= 1'b0;
            ptr       <= '0;
            dwell_cnt <= '0;
            prev_mode <= 1'b0;
        end else if (load) begin
            Out_Valid <= 1'b1;
            prev_mode <= Mode;
            if (Mode) begin
                Out     <= sel_data;
                Cur_Ch  <= eff;
                Sel_Err <= 1'b0;
                if (cnt_inc == CNT_W'(DWELL)) begin
                    ptr       <= nxt;
                    dwell_cnt <= '0;
                end else begin
                    ptr       <= eff;
                    dwell_cnt <= cnt_inc;
                end
            end else begin
                Out     <= sel_in_range ? sel_data : '0;
                Cur_Ch  <= Select_Line;
                Sel_Err <= ~sel_in_range;
                if (mode_sw) begin
                    ptr       <= '0;
                    dwell_cnt <= '0;
                end
            end
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end
endmodule

// File: doc/scan_mux_reg.md
Name: scan_mux_reg

Overview:
Registered, parametrised N-channel, W-bit multiplexer. It generalises the 8:1 single-bit mux to wide data and any channel count. It adds an auto-scan mode that walks a channel mask with a programmable dwell, and a valid/ready output handshake. It sits between parallel sensor or data channels and a single downstream consumer.

Parameters:
WIDTH, 8, data bits per channel.
CHANNELS, 8, number of input channels (2..256).
SEL_W, 3, select/channel-index width; must be >= clog2(CHANNELS).
DWELL, 4, accepted samples taken per channel before scan advances (>= 1).

Ports:
Clk  in  1  rising-edge clock.
Rst_n  in  1  asynchronous active-low reset.
I  in  CHANNELS*WIDTH  packed inputs; channel k = I[k*WIDTH +: WIDTH].
Select_Line  in  SEL_W  channel select in manual mode.
Mode  in  1  0 = manual, 1 = auto-scan.
Enable  in  1  permits new samples to be loaded.
Ch_Mask  in  CHANNELS  scan-mode channel enables; bit k = channel k.
Out_Ready  in  1  downstream accepts Out this cycle.
Out  out  WIDTH  registered selected data.
Out_Valid  out  1  Out holds an unaccepted sample.
Cur_Ch  out  SEL_W  channel index that produced Out.
Sel_Err  out  1  Out came from an out-of-range manual select.

Behaviour:
- Reset (Rst_n low, asynchronous): Out=0, Out_Valid=0, Cur_Ch=0, Sel_Err=0, scan pointer=0, dwell count=0, Prev_Mode=0. All outputs are held while Rst_n is low. Operation resumes on the first rising Clk after deassertion.
- Load condition: load = Enable & (~Out_Valid | Out_Ready) & channel_available.
  - channel_available is always 1 in manual mode.
  - In scan mode it is (Ch_Mask != 0).
- Latency: one cycle. Inputs sampled at edge t appear on Out after edge t.
- Handshake:
  - A transfer occurs when Out_Valid & Out_Ready.
  - While Out_Valid=1 and Out_Ready=0, Out, Cur_Ch and Sel_Err are frozen, whatever I, Select_Line, Mode or Mask do.
  - A transfer and a new load in the same cycle give back-to-back samples at full throughput.
  - Transfer with no load: Out_Valid drops to 0 next cycle; Out keeps its last value.
- Manual mode (Mode=0), on load:
  - If Select_Line < CHANNELS: Out <= channel Select_Line, Cur_Ch <= Select_Line, Sel_Err <= 0.
  - Otherwise: Out <= 0, Cur_Ch <= Select_Line, Sel_Err <= 1.
  - Out_Valid <= 1 in both cases.
- Scan mode (Mode=1):
  - Effective channel e = scan pointer if Ch_Mask[pointer]=1. Otherwise e = the next set mask bit searching upward from pointer+1, wrapping CHANNELS-1 -> 0.
  - On load: Out <= channel e, Cur_Ch <= e, Sel_Err <= 0.
  - If e != pointer: pointer <= e and dwell is treated as restarting at e.
  - Dwell count increments per load. When it reaches DWELL, it clears and the pointer advances to the next set mask bit after e, with wrap.
  - A single enabled channel is re-selected indefinitely.
- Mode switch:
  - When a load sees Mode differ from Prev_Mode, scan restarts: pointer=0, dwell=0.
  - The search rule above therefore starts from the lowest enabled channel.
  - Prev_Mode updates on every load.
- Mask edits mid-scan take effect at the next load through the effective-channel rule. No sample is emitted for a masked channel.
- Ch_Mask=0 in scan mode: no loads. The pending sample drains normally and Out_Valid then stays 0.
- Enable=0: no loads; the pending sample drains normally.
- Unused mask bits and index values >= CHANNELS never produce scan samples.

Test Plan:
(All scenarios: WIDTH=8, CHANNELS=8, DWELL=2, channel k input = 8'h10+k, unless noted.)
- Rst_n pulsed low mid-scan while Out_Valid=1 and Out_Ready=0 -> Out=0, Out_Valid=0, Cur_Ch=0 immediately without a clock edge. After release with Mode=1 and Ch_Mask=8'hFF, the first sample is 8'h10.
- Manual: Mode=0, Enable=1, Out_Ready=1, Select_Line=5 -> one cycle later Out=8'h15, Cur_Ch=5, Out_Valid=1. Select_Line=2 -> next cycle Out=8'h12.
- Backpressure: manual sample 8'h13 valid, Out_Ready=0 for 3 cycles while Select_Line changes to 6 -> Out stays 8'h13. Out_Ready=1 -> 8'h13 transfers, then 8'h16 follows next cycle.
- Scan with Ch_Mask=8'b1000_0101 and Out_Ready=1 -> accepted sequence 8'h10, 10, 12, 12, 17, 17, 10, 10. Clear bit 2 while on ch2 -> the next sample is 8'h17.
- Out-of-range: CHANNELS=6, SEL_W=3, Select_Line=7 -> Out=8'h00, Sel_Err=1, Out_Valid=1. Select_Line=4 -> Out=8'h14, Sel_Err=0.
- Scan with Ch_Mask=0 -> the pending sample transfers, Out_Valid=0 for 10 cycles. Ch_Mask=8'h08 -> 8'h13 appears repeatedly.
